// File: rtl/riscv_processor.sv
// Multi-cycle RV32I subset core: one instruction per FETCH/EXECUTE pair, with
// internal instruction and data memories and a live register-file output.
module riscv_processor #(
   parameter int PROG_DEPTH = 256,
   parameter int DATA_DEPTH = 256
) (
   input  logic               clk,
   input  logic               rst,
   output logic signed [31:0] GPR [0:31]
);

   // state   | meaning
   // S_FETCH | IR <= program_mem[PC], raise read_flag
   // S_EXEC  | decode IR, write rd / store, advance PC, drop read_flag
   typedef enum logic {S_FETCH, S_EXEC} state_t;

   // Depths are powers of two, so taking the low index bits is the modulo wrap.
   localparam int PAW = $clog2(PROG_DEPTH);
   localparam int DAW = $clog2(DATA_DEPTH);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   logic [31:0]        program_mem [0:PROG_DEPTH-1];
   logic [31:0]        data_mem    [0:DATA_DEPTH-1];
   logic               read_flag;
   state_t             state;
   logic [31:0]        pc;
   logic [31:0]        ir;
   logic signed [31:0] regs [0:31];

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] ld_addr;
   logic [31:0] st_addr;
   logic [DAW-1:0] ld_idx;
   logic [DAW-1:0] st_idx;

   assign opcode  = ir[6:0];
   assign rd      = ir[11:7];
   assign funct3  = ir[14:12];
   assign rs1     = ir[19:15];
   assign rs2     = ir[24:20];
   assign funct7  = ir[31:25];
   assign rs1_val = regs[rs1];
   assign rs2_val = regs[rs2];

   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u = {ir[31:12], 12'h000};
   assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   assign ld_addr = rs1_val + imm_i;
   assign st_addr = rs1_val + imm_s;
   assign ld_idx  = ld_addr[DAW+1:2];
   assign st_idx  = st_addr[DAW+1:2];

   logic unused_bits;
   assign unused_bits = ^{pc[1:0], pc[31:PAW+2], ld_addr[1:0], ld_addr[31:DAW+2],
                          st_addr[1:0], st_addr[31:DAW+2]};

   // ALU shared by OP and OP-IMM; funct7 bit 5 selects SUB / SRA / SRAI
   logic [31:0] alu_b;
   logic [4:0]  shamt;
   logic [31:0] alu_res;
   logic        alu_legal;

   always_comb begin
      alu_b     = (opcode == OPC_OP) ? rs2_val : imm_i;
      shamt     = alu_b[4:0];
      alu_res   = '0;
      alu_legal = 1'b0;
      case (funct3)
         3'b000: alu_res = (opcode == OPC_OP && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
         3'b001: alu_res = rs1_val << shamt;
         3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
         3'b011: alu_res = {31'd0, rs1_val < alu_b};
         3'b100: alu_res = rs1_val ^ alu_b;
         3'b101: alu_res = funct7[5] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
         3'b110: alu_res = rs1_val | alu_b;
         default: alu_res = rs1_val & alu_b;
      endcase
      if (opcode == OPC_OP) begin
         alu_legal = (funct7 == 7'h00) ||
                     (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
      end else begin
         case (funct3)
            3'b001:  alu_legal = (funct7 == 7'h00);
            3'b101:  alu_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            default: alu_legal = 1'b1;
         endcase
      end
   end

   logic br_taken;

   always_comb begin
      case (funct3)
         3'b000:  br_taken = (rs1_val == rs2_val);
         3'b001:  br_taken = (rs1_val != rs2_val);
         3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  br_taken = (rs1_val <  rs2_val);
         3'b111:  br_taken = (rs1_val >= rs2_val);
         default: br_taken = 1'b0;
      endcase
   end

   logic [31:0] next_pc;
   logic        wb_en;
   logic [31:0] wb_val;
   logic        st_en;

   // Anything not matched below falls through as a NOP: PC+4, no side effects.
   always_comb begin
      next_pc = pc + 32'd4;
      wb_en   = 1'b0;
      wb_val  = '0;
      st_en   = 1'b0;
      case (opcode)
         OPC_LUI: begin
            wb_en  = 1'b1;
            wb_val = imm_u;
         end
         OPC_AUIPC: begin
            wb_en  = 1'b1;
            wb_val = pc + imm_u;
         end
         OPC_JAL: begin
            wb_en   = 1'b1;
            wb_val  = pc + 32'd4;
            next_pc = pc + imm_j;
         end
         OPC_JALR: begin
            if (funct3 == 3'b000) begin
               wb_en   = 1'b1;
               wb_val  = pc + 32'd4;
               next_pc = ld_addr & ~32'd1;
            end
         end
         OPC_BRANCH: begin
            if (br_taken) next_pc = pc + imm_b;
         end
         OPC_LOAD: begin
            if (funct3 == 3'b010) begin
               wb_en  = 1'b1;
               wb_val = data_mem[ld_idx];
            end
         end
         OPC_STORE: st_en = (funct3 == 3'b010);
         OPC_OPIMM, OPC_OP: begin
            wb_en  = alu_legal;
            wb_val = alu_res;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         pc        <= '0;
         ir        <= '0;
         read_flag <= 1'b0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               ir        <= program_mem[pc[PAW+1:2]];
               read_flag <= 1'b1;
               state     <= S_EXEC;
            end
            S_EXEC: begin
               if (read_flag && wb_en && rd != 5'd0) regs[rd] <= wb_val;
               pc        <= next_pc;
               read_flag <= 1'b0;
               state     <= S_FETCH;
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   // Data memory is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (!rst && state == S_EXEC && read_flag && st_en) data_mem[st_idx] <= rs2_val;
   end

   assign GPR = regs;

endmodule

// File: tb/tb_riscv_processor.sv
// Bench for riscv_processor: directed programs from the test plan plus random
// programs compared against an instruction-level reference interpreter.
module tb_riscv_processor;

   logic               clk;
   logic               rst;
   logic signed [31:0] gpr [0:31];

   int checks = 0;
   int errors = 0;

   logic [31:0] prog  [0:255];
   logic [31:0] m_reg [0:31];
   logic [31:0] m_mem [0:255];
   logic [31:0] m_pc;

   riscv_processor #(.PROG_DEPTH(256), .DATA_DEPTH(256)) dut (
      .clk(clk),
      .rst(rst),
      .GPR(gpr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
      return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
      return {imm20[19:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_j(int imm, int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
   endfunction

   function automatic logic [31:0] addi(int rd, int rs1, int imm);
      return enc_i(imm, rs1, 0, rd, 7'h13);
   endfunction

   // Reference interpreter: executes one whole instruction from the RV32I rules.
   task automatic model_step();
      logic [31:0] w, a, b, ii, is, ib, iu, ij, res, npc;
      logic [6:0]  op, f7;
      logic [4:0]  rd, sh;
      logic [2:0]  f3;
      bit          wr;
      w   = prog[8'(m_pc >> 2)];
      op  = w[6:0];
      rd  = w[11:7];
      f3  = w[14:12];
      f7  = w[31:25];
      a   = m_reg[w[19:15]];
      b   = m_reg[w[24:20]];
      ii  = {{20{w[31]}}, w[31:20]};
      is  = {{20{w[31]}}, w[31:25], w[11:7]};
      ib  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      iu  = {w[31:12], 12'h000};
      ij  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      npc = m_pc + 4;
      wr  = 0;
      res = 0;
      case (op)
         7'h37: begin wr = 1; res = iu; end
         7'h17: begin wr = 1; res = m_pc + iu; end
         7'h6F: begin wr = 1; res = m_pc + 4; npc = m_pc + ij; end
         7'h67: if (f3 == 0) begin wr = 1; res = m_pc + 4; npc = (a + ii) & 32'hFFFF_FFFE; end
         7'h63: begin
            case (f3)
               0: if (a == b) npc = m_pc + ib;
               1: if (a != b) npc = m_pc + ib;
               4: if ($signed(a) < $signed(b)) npc = m_pc + ib;
               5: if ($signed(a) >= $signed(b)) npc = m_pc + ib;
               6: if (a < b) npc = m_pc + ib;
               7: if (a >= b) npc = m_pc + ib;
               default: ;
            endcase
         end
         7'h03: if (f3 == 2) begin wr = 1; res = m_mem[8'((a + ii) >> 2)]; end
         7'h23: if (f3 == 2) m_mem[8'((a + is) >> 2)] = b;
         7'h13: begin
            sh = ii[4:0];
            wr = 1;
            case (f3)
               0: res = a + ii;
               2: res = ($signed(a) < $signed(ii)) ? 1 : 0;
               3: res = (a < ii) ? 1 : 0;
               4: res = a ^ ii;
               6: res = a | ii;
               7: res = a & ii;
               1: if (f7 == 0) res = a << sh; else wr = 0;
               default: begin
                  if (f7 == 0) res = a >> sh;
                  else if (f7 == 7'h20) res = $signed(a) >>> sh;
                  else wr = 0;
               end
            endcase
         end
         7'h33: begin
            sh = b[4:0];
            wr = 1;
            case ({f7, f3})
               {7'h00, 3'd0}: res = a + b;
               {7'h20, 3'd0}: res = a - b;
               {7'h00, 3'd1}: res = a << sh;
               {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 1 : 0;
               {7'h00, 3'd3}: res = (a < b) ? 1 : 0;
               {7'h00, 3'd4}: res = a ^ b;
               {7'h00, 3'd5}: res = a >> sh;
               {7'h20, 3'd5}: res = $signed(a) >>> sh;
               {7'h00, 3'd6}: res = a | b;
               {7'h00, 3'd7}: res = a & b;
               default: wr = 0;
            endcase
         end
         default: ;
      endcase
      if (wr && rd != 0) m_reg[rd] = res;
      m_pc = npc;
   endtask

   task automatic load_prog(input logic [31:0] words [$]);
      for (int i = 0; i < 256; i++) prog[i] = (i < words.size()) ? words[i] : 32'h0;
      for (int i = 0; i < 256; i++) dut.program_mem[i] = prog[i];
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_reg[i] = 0;
      m_pc = 0;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic run(int n);
      repeat (n) begin
         repeat (2) @(negedge clk);
         model_step();
      end
   endtask

   task automatic test_reset();
      logic [31:0] q [$];
      q = {};
      load_prog(q);
      reset_dut();
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (gpr[i] !== 32'h0) begin
            errors++;
            $display("FAIL reset_gpr x%0d got %h want 0", i, gpr[i]);
         end
      end
      checks++;
      if (dut.pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_pc got %h want 0", dut.pc);
      end
      checks++;
      if (dut.read_flag !== 1'b0) begin
         errors++;
         $display("FAIL reset_read_flag got %b want 0", dut.read_flag);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (dut.read_flag !== ((i % 2) == 0)) begin
            errors++;
            $display("FAIL read_flag_toggle cycle %0d got %b want %b", i, dut.read_flag, (i % 2) == 0);
         end
      end
   endtask

   task automatic test_alu();
      logic [31:0] q [$];
      q = {addi(1, 0, 5), addi(2, 0, -3), enc_r(0, 2, 1, 0, 3), enc_r(32, 2, 1, 0, 4),
           enc_r(0, 1, 2, 2, 5), enc_r(0, 1, 2, 3, 6), enc_i(32'h401, 2, 5, 7, 7'h13)};
      load_prog(q);
      reset_dut();
      run(7);
      checks++;
      if (gpr[3] !== 32'd2) begin errors++; $display("FAIL alu_add got %h want 2", gpr[3]); end
      checks++;
      if (gpr[4] !== 32'd8) begin errors++; $display("FAIL alu_sub got %h want 8", gpr[4]); end
      checks++;
      if (gpr[5] !== 32'd1) begin errors++; $display("FAIL alu_slt got %h want 1", gpr[5]); end
      checks++;
      if (gpr[6] !== 32'd0) begin errors++; $display("FAIL alu_sltu got %h want 0", gpr[6]); end
      checks++;
      if (gpr[7] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL alu_srai got %h want fffffffe", gpr[7]); end
   endtask

   task automatic test_memory();
      logic [31:0] q [$];
      q = {addi(1, 0, 32'h55), enc_s(8, 1, 0), enc_i(8, 0, 2, 2, 7'h03), enc_i(9, 0, 2, 3, 7'h03)};
      load_prog(q);
      reset_dut();
      run(4);
      checks++;
      if (dut.data_mem[2] !== 32'h55) begin errors++; $display("FAIL mem_store got %h want 55", dut.data_mem[2]); end
      checks++;
      if (gpr[2] !== 32'h55) begin errors++; $display("FAIL mem_load got %h want 55", gpr[2]); end
      checks++;
      if (gpr[3] !== 32'h55) begin errors++; $display("FAIL mem_load_unaligned got %h want 55", gpr[3]); end
   endtask

   task automatic test_control();
      logic [31:0] q [$];
      q = {addi(1, 0, 3), addi(1, 1, -1), enc_b(-4, 0, 1, 1), enc_j(8, 5), addi(6, 0, 1), addi(7, 0, 9)};
      load_prog(q);
      reset_dut();
      run(9);
      checks++;
      if (gpr[1] !== 32'd0) begin errors++; $display("FAIL ctl_loop got %h want 0", gpr[1]); end
      checks++;
      if (gpr[5] !== 32'd16) begin errors++; $display("FAIL ctl_jal_link got %h want 10", gpr[5]); end
      checks++;
      if (gpr[6] !== 32'd0) begin errors++; $display("FAIL ctl_skipped got %h want 0", gpr[6]); end
      checks++;
      if (gpr[7] !== 32'd9) begin errors++; $display("FAIL ctl_target got %h want 9", gpr[7]); end
      checks++;
      if (dut.pc !== 32'd24) begin errors++; $display("FAIL ctl_pc got %h want 18", dut.pc); end
   endtask

   task automatic test_x0_utype();
      logic [31:0] q [$];
      q = {addi(0, 0, 7), enc_u(32'h12345, 8, 7'h37), enc_u(1, 9, 7'h17)};
      load_prog(q);
      reset_dut();
      run(3);
      checks++;
      if (gpr[0] !== 32'd0) begin errors++; $display("FAIL x0_write got %h want 0", gpr[0]); end
      checks++;
      if (gpr[8] !== 32'h1234_5000) begin errors++; $display("FAIL lui got %h want 12345000", gpr[8]); end
      checks++;
      if (gpr[9] !== 32'h0000_1008) begin errors++; $display("FAIL auipc got %h want 1008", gpr[9]); end
   endtask

   task automatic test_illegal_reset();
      logic [31:0] q [$];
      q = {addi(1, 0, 1), 32'hFFFF_FFFF, addi(2, 0, 2), addi(3, 0, 3)};
      load_prog(q);
      reset_dut();
      run(2);
      checks++;
      if (dut.pc !== 32'd8) begin errors++; $display("FAIL illegal_pc got %h want 8", dut.pc); end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (gpr[i] !== m_reg[i]) begin
            errors++;
            $display("FAIL illegal_gpr x%0d got %h want %h", i, gpr[i], m_reg[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (dut.read_flag !== 1'b1) begin errors++; $display("FAIL exec_phase got %b want 1", dut.read_flag); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      checks++;
      if (gpr[2] !== 32'd0) begin errors++; $display("FAIL abandoned_write got %h want 0", gpr[2]); end
      checks++;
      if (gpr[1] !== 32'd0) begin errors++; $display("FAIL midreset_clear got %h want 0", gpr[1]); end
      checks++;
      if (dut.pc !== 32'd0) begin errors++; $display("FAIL midreset_pc got %h want 0", dut.pc); end
      checks++;
      if (dut.read_flag !== 1'b0) begin errors++; $display("FAIL midreset_flag got %b want 0", dut.read_flag); end
      run(1);
      checks++;
      if (gpr[1] !== 32'd1 || dut.pc !== 32'd4) begin
         errors++;
         $display("FAIL restart got x1=%h pc=%h want x1=1 pc=4", gpr[1], dut.pc);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      int          rd, rs1, rs2, f3, sel;
      int          bf3 [6];
      logic [31:0] w;
      bf3 = '{0, 1, 4, 5, 6, 7};
      rd  = int'($urandom_range(0, 31));
      rs1 = int'($urandom_range(0, 15));
      rs2 = int'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
         0: w = enc_u(int'($urandom), rd, 7'h37);
         1: w = enc_u(int'($urandom), rd, 7'h17);
         2: begin
            f3 = int'($urandom_range(0, 7));
            if (f3 == 1)
               w = enc_i(int'($urandom_range(0, 31)), rs1, f3, rd, 7'h13);
            else if (f3 == 5)
               w = enc_i(int'($urandom_range(0, 31)) + ($urandom_range(0, 1) ? 32'h400 : 0), rs1, f3, rd, 7'h13);
            else
               w = enc_i(int'($urandom_range(0, 4095)), rs1, f3, rd, 7'h13);
         end
         3, 4: begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8) w = enc_r(0, rs2, rs1, sel, rd);
            else         w = enc_r(32, rs2, rs1, (sel == 8) ? 0 : 5, rd);
         end
         5: w = enc_s(int'($urandom_range(0, 63)), rs2, 0);
         6: w = enc_i(int'($urandom_range(0, 63)), 0, 2, rd, 7'h03);
         7: w = enc_b($urandom_range(0, 1) ? 8 : 12, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), bf3[$urandom_range(0, 5)]);
         8: w = enc_j(8, rd);
         default: w = $urandom;
      endcase
      return w;
   endfunction

   task automatic test_random(int iters);
      logic [31:0] q [$];
      for (int t = 0; t < iters; t++) begin
         q = {};
         for (int r = 1; r < 8; r++) begin
            q.push_back(enc_u(int'($urandom), r, 7'h37));
            q.push_back(addi(r, r, int'($urandom_range(0, 4095))));
         end
         for (int k = 0; k < 48; k++) q.push_back(rand_instr());
         load_prog(q);
         reset_dut();
         run(q.size() + 4);
         for (int i = 0; i < 32; i++) begin
            checks++;
            if (gpr[i] !== m_reg[i]) begin
               errors++;
               $display("FAIL rand%0d_gpr x%0d got %h want %h", t, i, gpr[i], m_reg[i]);
            end
         end
         checks++;
         if (dut.pc !== m_pc) begin
            errors++;
            $display("FAIL rand%0d_pc got %h want %h", t, dut.pc, m_pc);
         end
         for (int i = 0; i < 256; i++) begin
            checks++;
            if (dut.data_mem[i] !== m_mem[i]) begin
               errors++;
               $display("FAIL rand%0d_mem [%0d] got %h want %h", t, i, dut.data_mem[i], m_mem[i]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 256; i++) m_mem[i] = 0;
      model_reset();
      test_reset();
      test_alu();
      test_memory();
      test_control();
      test_x0_utype();
      test_illegal_reset();
      test_random(6);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
